// File: rtl/fpu_pkg.sv
// fpu_pkg: shared FP widths, tag record and sign-flip helper for the add/sub scheduler.
package fpu_pkg;
  localparam int FP_W = 32;
  localparam int FSUB_LATENCY = 3;
  localparam int IDX_W = 3;
  typedef struct packed {
    logic v;
    logic [IDX_W-1:0] idx;
  } tag_t;
  function automatic logic [FP_W-1:0] flip_sign(input logic [FP_W-1:0] x);
    return {~x[FP_W-1], x[FP_W-2:0]};
  endfunction
endpackage

// File: rtl/fpu_addsub_sched_rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant among eligible requesters, search starts at ptr.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IW = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] elig_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IW-1:0]   idx_o
);
  logic [IW-1:0] ptr_q, ptr_d;
  // Walk offsets from farthest to nearest so the requester closest to ptr wins.
  always_comb begin
    grant_o = '0;
    idx_o = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (elig_i[(int'(ptr_q) + k) % NREQ]) begin
        grant_o = '0;
        grant_o[(int'(ptr_q) + k) % NREQ] = 1'b1;
        idx_o = IW'((int'(ptr_q) + k) % NREQ);
      end
    end
  end
  assign ptr_d = !(|grant_o) ? ptr_q : (idx_o == IW'(NREQ - 1)) ? '0 : idx_o + 1'b1;
  always_ff @(posedge clk) begin
    ptr_q <= rst ? '0 : ptr_d;
  end
endmodule

// File: rtl/fpu_addsub_sched.sv
// fpu_addsub_sched: shares one fixed-latency FP add/sub unit among NREQ requesters,
// limiting in-flight ops per requester and routing each result back via a tag pipe.
module fpu_addsub_sched
  import fpu_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int LATENCY = FSUB_LATENCY,
  parameter int MAX_OUT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid_i,
  output logic [NREQ-1:0]      req_ready_o,
  input  logic [NREQ-1:0]      req_sub_i,
  input  logic [NREQ*FP_W-1:0] req_a_i,
  input  logic [NREQ*FP_W-1:0] req_b_i,
  output logic [FP_W-1:0]      fu_a_o,
  output logic [FP_W-1:0]      fu_b_o,
  input  logic [FP_W-1:0]      fu_result_i,
  output logic [NREQ-1:0]      resp_valid_o,
  output logic [FP_W-1:0]      resp_data_o
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(MAX_OUT + 1);
  logic [NREQ-1:0] elig, grant;
  logic [IW-1:0] gidx;
  logic [FP_W-1:0] sel_a, sel_b;
  tag_t tag_q [LATENCY];
  logic [CW-1:0] cnt_q [NREQ];
  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk(clk),
    .rst(rst),
    .elig_i(elig),
    .grant_o(grant),
    .idx_o(gidx)
  );
  for (genvar i = 0; i < NREQ; i++) begin : g_req
    assign resp_valid_o[i] = tag_q[LATENCY-1].v && tag_q[LATENCY-1].idx == IDX_W'(i);
    // A response retiring this cycle frees a slot, so a full requester may reissue at once.
    assign elig[i] = !rst && req_valid_i[i] && (cnt_q[i] < CW'(MAX_OUT) || resp_valid_o[i]);
    always_ff @(posedge clk) begin
      cnt_q[i] <= rst ? '0 : cnt_q[i] + CW'(grant[i]) - CW'(resp_valid_o[i]);
    end
  end
  assign req_ready_o = grant;
  assign sel_a = req_a_i[int'(gidx)*FP_W +: FP_W];
  assign sel_b = req_b_i[int'(gidx)*FP_W +: FP_W];
  assign fu_a_o = |grant ? sel_a : '0;
  assign fu_b_o = !(|grant) ? '0 : req_sub_i[gidx] ? sel_b : flip_sign(sel_b);
  assign resp_data_o = fu_result_i;
  always_ff @(posedge clk) begin
    tag_q[0] <= rst ? '0 : tag_t'{v: |grant, idx: IDX_W'(gidx)};
    for (int k = 1; k < LATENCY; k++) tag_q[k] <= rst ? '0 : tag_q[k-1];
  end
endmodule

// File: tb/tb_fpu_addsub_sched.sv
// tb_fpu_addsub_sched: directed vectors plus multi-cycle sequences against a stand-in 3-stage unit.
module tb_fpu_addsub_sched;
  localparam int NREQ = 2;
  localparam int LAT = 3;
  logic clk = 0;
  logic rst = 1;
  logic [1:0] req_valid = '0, req_sub = '0, req_ready, resp_valid;
  logic [63:0] req_a = '0, req_b = '0;
  logic [31:0] fu_a, fu_b, fu_result, resp_data;
  logic [31:0] ua [LAT], ub [LAT];
  int pass_cnt = 0, total = 0;

  fpu_addsub_sched #(.NREQ(NREQ), .LATENCY(LAT), .MAX_OUT(2)) dut (
    .clk(clk), .rst(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_sub_i(req_sub), .req_a_i(req_a), .req_b_i(req_b), .fu_a_o(fu_a), .fu_b_o(fu_b),
    .fu_result_i(fu_result), .resp_valid_o(resp_valid), .resp_data_o(resp_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] fake_sub(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h40400000 && b == 32'h3F800000) return 32'h40000000;
    if (a == 32'h3F800000 && b == 32'hBF800000) return 32'h40000000;
    return a ^ b;
  endfunction

  always @(posedge clk) begin
    ua[0] <= fu_a;
    ub[0] <= fu_b;
    for (int k = 1; k < LAT; k++) begin
      ua[k] <= ua[k-1];
      ub[k] <= ub[k-1];
    end
  end
  assign fu_result = fake_sub(ua[LAT-1], ub[LAT-1]);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    req_valid = '0;
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  typedef struct {
    int r;
    logic sub;
    logic [31:0] a, b, exp_fub, exp_data;
  } vec_t;
  vec_t vecs [4];
  logic exp_r [7];

  initial begin
    vecs[0] = '{0, 1'b1, 32'h40400000, 32'h3F800000, 32'h3F800000, 32'h40000000};
    vecs[1] = '{1, 1'b0, 32'h3F800000, 32'h3F800000, 32'hBF800000, 32'h40000000};
    vecs[2] = '{1, 1'b0, 32'h12345678, 32'h80000001, 32'h00000001, 32'h12345679};
    vecs[3] = '{0, 1'b0, 32'hC0000000, 32'h7F800000, 32'hFF800000, 32'h3F800000};
    exp_r = '{1, 1, 0, 1, 1, 0, 1};
    // reset held with both requesters asserting valid
    req_valid = 2'b11;
    @(negedge clk);
    #1 chk("rst_ready_c1", 32'(req_ready), 32'h0);
    @(negedge clk);
    #1 chk("rst_ready_c2", 32'(req_ready), 32'h0);
    chk("rst_resp_c2", 32'(resp_valid), 32'h0);
    rst = 0;
    #1 chk("rel_ready", 32'(req_ready), 32'h1);
    for (int v = 0; v < 4; v++) begin
      @(negedge clk);
      req_valid = 2'b01 << vecs[v].r;
      req_sub[vecs[v].r] = vecs[v].sub;
      req_a[vecs[v].r*32 +: 32] = vecs[v].a;
      req_b[vecs[v].r*32 +: 32] = vecs[v].b;
      #1 chk($sformatf("v%0d_ready", v), 32'(req_ready), 32'(req_valid));
      chk($sformatf("v%0d_fu_a", v), fu_a, vecs[v].a);
      chk($sformatf("v%0d_fu_b", v), fu_b, vecs[v].exp_fub);
      @(negedge clk);
      req_valid = '0;
      #1 chk($sformatf("v%0d_idle_fu_a", v), fu_a, 32'h0);
      repeat (2) @(negedge clk);
      #1 chk($sformatf("v%0d_resp_valid", v), 32'(resp_valid), 32'(2'b01 << vecs[v].r));
      chk($sformatf("v%0d_resp_data", v), resp_data, vecs[v].exp_data);
    end
    // contention: both requesters valid every cycle
    do_reset();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      req_valid = 2'b11;
      #1 chk($sformatf("cont_ready_c%0d", c), 32'(req_ready), (c % 2 == 1) ? 32'h2 : 32'h1);
      chk($sformatf("cont_resp_c%0d", c), 32'(resp_valid),
          (c < 3) ? 32'h0 : ((c - 3) % 2 == 1) ? 32'h2 : 32'h1);
    end
    // outstanding limit with a lone requester
    do_reset();
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      req_valid = 2'b01;
      #1 chk($sformatf("lim_ready_c%0d", c), 32'(req_ready), 32'(exp_r[c]));
      chk($sformatf("lim_resp_c%0d", c), 32'(resp_valid), (c < 3) ? 32'h0 : 32'(exp_r[c-3]));
    end
    // reset while an op is in flight
    do_reset();
    @(negedge clk);
    req_valid = 2'b01;
    #1 chk("mid_issue_ready", 32'(req_ready), 32'h1);
    @(negedge clk);
    req_valid = '0;
    rst = 1;
    for (int c = 2; c < 5; c++) begin
      @(negedge clk);
      rst = 0;
      #1 chk($sformatf("mid_resp_c%0d", c), 32'(resp_valid), 32'h0);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      req_valid = 2'b01;
      #1 chk($sformatf("mid_resume_c%0d", c), 32'(req_ready), (c < 2) ? 32'h1 : 32'h0);
    end
    @(negedge clk);
    req_valid = '0;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
